// File: rtl/mor1kx_pcu_wide_if.sv
// SPR bus bundle between the pipeline's SPR access path and the performance counter unit.
interface mor1kx_pcu_wide_if;
    logic        spr_access_i;
    logic        spr_we_i;
    logic        spr_re_i;
    logic [15:0] spr_addr_i;
    logic [31:0] spr_dat_i;
    logic        spr_bus_ack;
    logic [31:0] spr_dat_o;

    modport master (output spr_access_i, spr_we_i, spr_re_i, spr_addr_i, spr_dat_i,
                    input  spr_bus_ack, spr_dat_o);
    modport slave  (input  spr_access_i, spr_we_i, spr_re_i, spr_addr_i, spr_dat_i,
                    output spr_bus_ack, spr_dat_o);
endinterface

// File: rtl/mor1kx_pcu_wide.sv
// Wide performance counter unit: NUM_COUNTERS event counters of COUNTER_WIDTH bits,
// with SPR access to the counters (low/high halves), their mode registers and a global control register.
`default_nettype none

module mor1kx_pcu_wide_cnt #(
    parameter int W  = 48,
    parameter int NE = 11
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          sys,
    input  wire logic          freeze,
    input  wire logic [NE-1:0] ev,
    input  wire logic          wr_lo,
    input  wire logic          wr_hi,
    input  wire logic          wr_mr,
    input  wire logic          rd_lo,
    input  wire logic [31:0]   dat,
    output logic [31:0]        lo,
    output logic [31:0]        hi,
    output logic [31:0]        mr,
    output logic               ovf_set,
    output logic               ovie
);
    logic [W-1:0]  cnt, cnt_nxt, hi_merge;
    logic [W:0]    sum;
    logic [NE-1:0] mask;
    logic [4:0]    inc;
    logic          cism, cium, en;

    always_comb begin
        inc = '0;
        for (int i = 0; i < NE; i++) inc = inc + 5'(ev[i] & mask[i]);
    end

    assign en      = ~freeze & ((cism & sys) | (cium & ~sys));
    assign sum     = {1'b0, cnt} + (W+1)'(inc);
    // A software write to either half swallows this cycle's increment and its carry.
    assign ovf_set = en & sum[W] & ~wr_lo & ~wr_hi;

    always_comb begin
        cnt_nxt = cnt;
        if (wr_lo)      cnt_nxt[31:0] = dat;
        else if (wr_hi) cnt_nxt = hi_merge;
        else if (en)    cnt_nxt = sum[W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            cism <= 1'b0;
            cium <= 1'b0;
            mask <= '0;
            ovie <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            if (wr_mr) begin
                cism <= dat[0];
                cium <= dat[1];
                mask <= dat[NE+1:2];
                ovie <= dat[31];
            end
        end
    end

    // Upper half is captured on a low-half read so software gets a coherent 64-bit snapshot.
    generate
        if (W > 32) begin : g_hi
            logic [W-33:0] shadow;
            assign hi_merge = {dat[W-33:0], cnt[31:0]};
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)     shadow <= '0;
                else if (rd_lo) shadow <= cnt[W-1:32];
            end
            assign hi = 32'(shadow);
        end else begin : g_nohi
            logic unused_hi;
            assign unused_hi = wr_hi ^ rd_lo;
            assign hi_merge  = cnt;
            assign hi        = '0;
        end
    endgenerate

    assign lo = cnt[31:0];

    always_comb begin
        mr         = '0;
        mr[0]      = cism;
        mr[1]      = cium;
        mr[NE+1:2] = mask;
        mr[31]     = ovie;
    end
endmodule

module mor1kx_pcu_wide #(
    parameter int NUM_COUNTERS  = 8,
    parameter int COUNTER_WIDTH = 48,
    parameter int NUM_EVENTS    = 11
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    mor1kx_pcu_wide_if.slave           spr,
    input  wire logic                  spr_sys_mode_i,
    input  wire logic [NUM_EVENTS-1:0] pcu_event_i,
    output logic                       pcu_irq_o
);
    logic [2:0] cls, idx;
    logic       acc_we, acc_re, gr_we, freeze;
    logic [NUM_COUNTERS-1:0]        ovf, ovf_set, ovie;
    logic [NUM_COUNTERS-1:0][31:0]  lo_v, hi_v, mr_v;
    logic [31:0] rdat;
    logic        unused_addr;

    assign cls         = spr.spr_addr_i[5:3];
    assign idx         = spr.spr_addr_i[2:0];
    assign unused_addr = ^spr.spr_addr_i[15:6];
    assign acc_we      = spr.spr_access_i & spr.spr_we_i & spr_sys_mode_i;
    assign acc_re      = spr.spr_access_i & spr.spr_re_i;
    assign gr_we       = acc_we && cls == 3'd3 && idx == 3'd0;

    generate
        for (genvar n = 0; n < NUM_COUNTERS; n++) begin : g_cnt
            mor1kx_pcu_wide_cnt #(.W(COUNTER_WIDTH), .NE(NUM_EVENTS)) u_cnt (
                .clk     (clk),
                .rst_n   (rst_n),
                .sys     (spr_sys_mode_i),
                .freeze  (freeze),
                .ev      (pcu_event_i),
                .wr_lo   (acc_we && cls == 3'd0 && idx == 3'(n)),
                .wr_hi   (acc_we && cls == 3'd1 && idx == 3'(n)),
                .wr_mr   (acc_we && cls == 3'd2 && idx == 3'(n)),
                .rd_lo   (acc_re && cls == 3'd0 && idx == 3'(n)),
                .dat     (spr.spr_dat_i),
                .lo      (lo_v[n]),
                .hi      (hi_v[n]),
                .mr      (mr_v[n]),
                .ovf_set (ovf_set[n]),
                .ovie    (ovie[n])
            );
        end
    endgenerate

    // New overflows win over a same-cycle write-1-to-clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freeze    <= 1'b0;
            ovf       <= '0;
            pcu_irq_o <= 1'b0;
        end else begin
            if (gr_we) freeze <= spr.spr_dat_i[31];
            ovf       <= ovf_set | (ovf & ~(gr_we ? spr.spr_dat_i[NUM_COUNTERS-1:0] : '0));
            pcu_irq_o <= |(ovf & ovie);
        end
    end

    always_comb begin
        rdat = '0;
        if (acc_re) begin
            for (int n = 0; n < NUM_COUNTERS; n++) begin
                if (idx == 3'(n)) begin
                    case (cls)
                        3'd0:    rdat = lo_v[n];
                        3'd1:    rdat = hi_v[n];
                        3'd2:    if (spr_sys_mode_i) rdat = mr_v[n];
                        default: ;
                    endcase
                end
            end
            if (cls == 3'd3 && idx == 3'd0 && spr_sys_mode_i) begin
                rdat[31]               = freeze;
                rdat[NUM_COUNTERS-1:0] = ovf;
            end
        end
    end

    assign spr.spr_dat_o   = rdat;
    assign spr.spr_bus_ack = spr.spr_access_i;
endmodule

`default_nettype wire

// File: tb/tb_mor1kx_pcu_wide.sv
// Scoreboard bench for mor1kx_pcu_wide: reads push expected data, a negedge monitor checks each ack'd read.
module tb_mor1kx_pcu_wide;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sys = 1'b1;
    logic [10:0] ev = '0;
    logic        irq;
    int          errors = 0;
    int          checks = 0;
    string       qn[$];
    logic [31:0] qv[$];

    mor1kx_pcu_wide_if bus();

    mor1kx_pcu_wide #(.NUM_COUNTERS(8), .COUNTER_WIDTH(48), .NUM_EVENTS(11)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .spr            (bus.slave),
        .spr_sys_mode_i (sys),
        .pcu_event_i    (ev),
        .pcu_irq_o      (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.spr_bus_ack && bus.spr_re_i) begin
            if (qv.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read: got %h expected none", bus.spr_dat_o);
            end else begin
                chk(qn.pop_front(), bus.spr_dat_o, qv.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] c, input logic [2:0] i, input logic [31:0] d);
        bus.spr_access_i = 1'b1;
        bus.spr_we_i     = 1'b1;
        bus.spr_addr_i   = {10'b0, c, i};
        bus.spr_dat_i    = d;
        tick(1);
        bus.spr_access_i = 1'b0;
        bus.spr_we_i     = 1'b0;
    endtask

    task automatic rd(input string nm, input logic [2:0] c, input logic [2:0] i, input logic [31:0] exp);
        qn.push_back(nm);
        qv.push_back(exp);
        bus.spr_access_i = 1'b1;
        bus.spr_re_i     = 1'b1;
        bus.spr_addr_i   = {10'b0, c, i};
        tick(1);
        bus.spr_access_i = 1'b0;
        bus.spr_re_i     = 1'b0;
    endtask

    task automatic pulse(input logic [10:0] e, input int n);
        ev = e;
        tick(n);
        ev = '0;
    endtask

    initial begin
        bus.spr_access_i = 1'b0;
        bus.spr_we_i     = 1'b0;
        bus.spr_re_i     = 1'b0;
        bus.spr_addr_i   = '0;
        bus.spr_dat_i    = '0;
        ev = 11'h7FF;
        #12 rst_n = 1'b1;
        tick(2);
        ev = '0;
        rd("reset_lo0", 3'd0, 3'd0, 32'h0);
        rd("reset_pcmr0", 3'd2, 3'd0, 32'h0);
        rd("reset_pcgr", 3'd3, 3'd0, 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);

        // five single-event cycles
        wr(3'd2, 3'd0, 32'h7);
        pulse(11'h001, 5);
        rd("cnt0_five", 3'd0, 3'd0, 32'd5);

        // all eleven events in one cycle
        wr(3'd2, 3'd1, 32'h1FFD);
        pulse(11'h7FF, 1);
        rd("cnt1_eleven", 3'd0, 3'd1, 32'd11);
        rd("pcmr1", 3'd2, 3'd1, 32'h1FFD);
        rd("cnt0_six", 3'd0, 3'd0, 32'd6);

        // 48-bit wrap, overflow flag and interrupt
        wr(3'd2, 3'd2, 32'h8000_0005);
        wr(3'd0, 3'd2, 32'hFFFF_FFFF);
        wr(3'd1, 3'd2, 32'h0000_FFFF);
        rd("cnt2_lo_max", 3'd0, 3'd2, 32'hFFFF_FFFF);
        rd("cnt2_hi_max", 3'd1, 3'd2, 32'h0000_FFFF);
        pulse(11'h001, 1);
        chk("irq_not_same_cycle", 32'(irq), 32'h0);
        tick(1);
        chk("irq_set", 32'(irq), 32'h1);
        rd("cnt2_lo_wrap", 3'd0, 3'd2, 32'h0);
        rd("cnt2_hi_wrap", 3'd1, 3'd2, 32'h0);
        rd("pcgr_ovf2", 3'd3, 3'd0, 32'h4);
        wr(3'd3, 3'd0, 32'h4);
        chk("irq_hold_after_clear", 32'(irq), 32'h1);
        tick(1);
        chk("irq_drop", 32'(irq), 32'h0);
        rd("pcgr_cleared", 3'd3, 3'd0, 32'h0);

        // high-half shadow
        wr(3'd2, 3'd3, 32'h5);
        wr(3'd0, 3'd3, 32'hFFFF_FFFF);
        wr(3'd1, 3'd3, 32'h1);
        rd("cnt3_lo", 3'd0, 3'd3, 32'hFFFF_FFFF);
        pulse(11'h001, 2);
        rd("cnt3_hi_shadow", 3'd1, 3'd3, 32'h1);
        rd("cnt3_lo_after", 3'd0, 3'd3, 32'h1);
        rd("cnt3_hi_new", 3'd1, 3'd3, 32'h2);

        // write beats same-cycle increment
        wr(3'd2, 3'd4, 32'h5);
        ev = 11'h001;
        wr(3'd0, 3'd4, 32'h10);
        ev = '0;
        rd("cnt4_write_prio", 3'd0, 3'd4, 32'h10);

        // overflow set beats same-cycle W1C
        wr(3'd2, 3'd5, 32'h5);
        wr(3'd0, 3'd5, 32'hFFFF_FFFF);
        wr(3'd1, 3'd5, 32'h0000_FFFF);
        ev = 11'h001;
        wr(3'd3, 3'd0, 32'h20);
        ev = '0;
        rd("pcgr_set_prio", 3'd3, 3'd0, 32'h20);
        wr(3'd3, 3'd0, 32'h20);
        rd("pcgr_w1c", 3'd3, 3'd0, 32'h0);

        // user mode and freeze
        wr(3'd0, 3'd3, 32'h100);
        sys = 1'b0;
        wr(3'd2, 3'd0, 32'h3);
        rd("user_pcmr0", 3'd2, 3'd0, 32'h0);
        rd("user_lo3", 3'd0, 3'd3, 32'h100);
        pulse(11'h001, 2);
        rd("user_lo3_cism_only", 3'd0, 3'd3, 32'h100);
        rd("user_pcgr", 3'd3, 3'd0, 32'h0);
        sys = 1'b1;
        rd("pcmr0_unchanged", 3'd2, 3'd0, 32'h7);
        wr(3'd0, 3'd0, 32'h0);
        wr(3'd3, 3'd0, 32'h8000_0000);
        pulse(11'h7FF, 3);
        sys = 1'b0;
        pulse(11'h001, 2);
        sys = 1'b1;
        rd("frozen_lo0", 3'd0, 3'd0, 32'h0);
        rd("pcgr_freeze", 3'd3, 3'd0, 32'h8000_0000);
        wr(3'd3, 3'd0, 32'h0);

        // unmapped accesses
        wr(3'd3, 3'd1, 32'h8000_0000);
        rd("pcgr1_zero", 3'd3, 3'd1, 32'h0);
        rd("class4_zero", 3'd4, 3'd0, 32'h0);
        rd("pcgr_untouched", 3'd3, 3'd0, 32'h0);
        bus.spr_re_i   = 1'b1;
        bus.spr_addr_i = 16'h0003;
        #1 chk("no_access_dat", bus.spr_dat_o, 32'h0);
        chk("no_access_ack", 32'(bus.spr_bus_ack), 32'h0);
        bus.spr_re_i = 1'b0;
        tick(1);

        // asynchronous reset mid-cycle
        wr(3'd0, 3'd2, 32'hFFFF_FFFF);
        wr(3'd1, 3'd2, 32'h0000_FFFF);
        pulse(11'h001, 1);
        tick(1);
        chk("irq_before_reset", 32'(irq), 32'h1);
        ev = 11'h001;
        #3 rst_n = 1'b0;
        #1 chk("async_irq", 32'(irq), 32'h0);
        bus.spr_access_i = 1'b1;
        bus.spr_re_i     = 1'b1;
        bus.spr_addr_i   = {10'b0, 3'd0, 3'd1};
        #1 chk("async_lo1", bus.spr_dat_o, 32'h0);
        bus.spr_addr_i   = {10'b0, 3'd1, 3'd3};
        #1 chk("async_hi3_shadow", bus.spr_dat_o, 32'h0);
        bus.spr_access_i = 1'b0;
        bus.spr_re_i     = 1'b0;
        #4 rst_n = 1'b1;
        tick(1);
        ev = '0;
        rd("post_reset_lo0", 3'd0, 3'd0, 32'h0);
        rd("post_reset_pcmr2", 3'd2, 3'd2, 32'h0);
        rd("post_reset_pcgr", 3'd3, 3'd0, 32'h0);

        for (int i = 0; i < 10 && qv.size() != 0; i++) tick(1);
        if (qv.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL pending_reads: got %0d outstanding expected 0", qv.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mor1kx_pcu_wide.md
MOR1KX_PCU_WIDE -- requirements
Module: mor1kx_pcu_wide

Interface
REQ-001 SHALL have parameter NUM_COUNTERS, default 8, counter count (1..8).
REQ-002 SHALL have parameter COUNTER_WIDTH, default 48, counter bits (32..64).
REQ-003 SHALL have parameter NUM_EVENTS, default 11, event input count (1..16).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port spr_access_i  input  1  SPR access to this unit.
REQ-007 SHALL have port spr_we_i  input  1  SPR write strobe.
REQ-008 SHALL have port spr_re_i  input  1  SPR read strobe.
REQ-009 SHALL have port spr_addr_i  input  16  SPR address.
REQ-010 SHALL have port spr_dat_i  input  32  SPR write data.
REQ-011 SHALL have port spr_bus_ack  output  1  equals spr_access_i, combinational.
REQ-012 SHALL have port spr_dat_o  output  32  read data, combinational, 0 when not reading.
REQ-013 SHALL have port spr_sys_mode_i  input  1  1 = supervisor, 0 = user.
REQ-014 SHALL have port pcu_event_i  input  NUM_EVENTS  per-cycle event pulses.
REQ-015 SHALL have port pcu_irq_o  output  1  registered overflow interrupt.

Function
REQ-016 SHALL decode spr_addr_i[5:3] as register class (0 PCCR_LO, 1 PCCR_HI, 2 PCMR, 3 PCGR) and spr_addr_i[2:0] as counter index n.
REQ-017 SHALL define PCMR[n]: bit0 CISM, bit1 CIUM, bits[NUM_EVENTS+1:2] event mask, bit31 OVIE; other bits read 0.
REQ-018 SHALL define PCGR (index 0 only): bit31 FREEZE; bits[NUM_COUNTERS-1:0] sticky OVF flags, write-1-to-clear.
REQ-019 SHALL increment counter n each cycle by popcount(pcu_event_i & mask[n]) when FREEZE=0 and ((CISM & sys) | (CIUM & ~sys)).
REQ-020 SHALL wrap counters modulo 2^COUNTER_WIDTH and set OVF[n] in the cycle the addition carries out.
REQ-021 SHALL read PCCR_LO as counter bits [31:0] and, in the same cycle, latch bits [W-1:32] into a per-counter shadow register.
REQ-022 SHALL read PCCR_HI as the shadow, zero-extended; returns 0 when COUNTER_WIDTH=32.
REQ-023 SHALL write PCCR_LO to bits [31:0] and PCCR_HI to bits [W-1:32], other half unchanged.
REQ-024 SHALL accept writes only when spr_sys_mode_i=1; user-mode writes ignored, still acked.
REQ-025 SHALL return 0 for PCMR and PCGR reads in user mode; PCCR reads allowed in any mode.
REQ-026 SHALL return 0 on reads and ignore writes for n >= NUM_COUNTERS, PCGR n != 0, class 4..7.
REQ-027 SHALL give an SPR counter write priority over that cycle's increment (increment dropped, no OVF from it).
REQ-028 SHALL give a new overflow set priority over a simultaneous W1C clear of the same flag.
REQ-029 SHALL drive pcu_irq_o one cycle after any (OVF[n] & OVIE[n]) becomes 1, and deassert one cycle after all clear.
REQ-030 SHALL ignore spr_we_i/spr_re_i when spr_access_i=0.

Reset
REQ-031 SHALL on rst_n=0 asynchronously clear all counters, shadows, PCMR, PCGR and pcu_irq_o to 0.
REQ-032 SHALL leave no event counted in the first rising edge after rst_n deasserts unless enables were written.

Verification
REQ-033 Sys mode, PCMR0=0x7 (CISM, event0), pulse event0 5 cycles -> PCCR_LO0 reads 5.
REQ-034 PCMR1 masks events 0..10, all 11 pulse one cycle -> counter1 increases by 11 in one cycle.
REQ-035 W=48, write counter2 = 0xFFFF_FFFF_FFFF, OVIE set, one event -> counter 0, OVF[2]=1, pcu_irq_o=1 next cycle; write PCGR 0x4 -> irq drops next cycle.
REQ-036 Counter3=0x1_FFFF_FFFF, read LO (0xFFFFFFFF), two events, read HI -> 0x1 (shadow), next LO read 0x00000001.
REQ-037 User mode: write PCMR0 0x3 -> unchanged; PCMR read returns 0; PCCR read returns live value; FREEZE=1 -> no counting.
REQ-038 Assert rst_n mid-count between edges -> all counters and irq 0 immediately, before next clk edge.
